// File: rtl/mcp300x_scan_adc_if.sv
// Conversion-result stream: tagged ADC samples moving from the scanner to a consumer over valid/ready.
interface mcp300x_scan_adc_if #(
    parameter int RES_BITS = 10
);
    logic [RES_BITS-1:0] sample_data;
    logic [2:0]          sample_ch;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/mcp300x_scan_adc.sv
// Round-robin scanning SPI master for MCP3004/3008 (10-bit) and MCP3204/3208 (12-bit) ADCs.
// Each frame sends a start/mode/channel command, shifts in the result MSB first and publishes it tagged.
module mcp300x_scan_adc #(
    parameter int CLK_DIV    = 2700,
    parameter int RES_BITS   = 10,
    parameter int NUM_CH     = 8,
    parameter int GAP_HALVES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [7:0]         ch_mask,
    input  logic               diff_mode,
    output logic               AD_CLK,
    output logic               CS,
    output logic               DIN,
    input  logic               DOUT,
    mcp300x_scan_adc_if.master smp,
    output logic               overrun,
    input  logic               overrun_clr
);
    localparam int NBITS    = 7 + RES_BITS;
    localparam int SHIFT_HP = 2 * NBITS;
    localparam int HP_MAX   = (SHIFT_HP > GAP_HALVES) ? SHIFT_HP : GAP_HALVES;
    localparam int HW       = $clog2(HP_MAX + 1);
    localparam int CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [7:0]    CH_LIMIT   = (NUM_CH == 4) ? 8'h0F : 8'hFF;
    localparam logic [2:0]    CH_WRAP    = 3'(NUM_CH - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [HW-1:0] SHIFT_LAST = HW'(SHIFT_HP - 1);
    localparam logic [HW-1:0] GAP_LAST   = HW'(GAP_HALVES - 1);
    localparam logic [HW-2:0] K_SGL      = (HW-1)'(0);
    localparam logic [HW-2:0] K_D2       = (HW-1)'(1);
    localparam logic [HW-2:0] K_D1       = (HW-1)'(2);
    localparam logic [HW-2:0] K_D0       = (HW-1)'(3);
    localparam logic [HW-2:0] K_DATA     = (HW-1)'(7);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [HW-1:0]       half_q, half_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          ch_q, ch_d;
    logic [2:0]          smp_ch_q, smp_ch_d;
    logic                diff_q, diff_d;
    logic                adclk_q, adclk_d;
    logic                cs_q, cs_d;
    logic                din_q, din_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic [RES_BITS-1:0] shreg_q, shreg_d;
    logic [RES_BITS-1:0] data_q, data_d;

    logic                tick_s;
    logic                sel_ok_s;
    logic [7:0]          eff_mask_s;
    logic [2:0]          sel_ch_s;
    logic [HW-2:0]       bit_k_s;

    // Half-period tick; the counter sits at zero in IDLE and HOLD so each frame and gap start aligned.
    assign tick_s  = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    assign bit_k_s = half_q[HW-1:1];

    // Pick the first enabled channel at or after the scan pointer, wrapping at NUM_CH.
    always_comb begin
        logic [2:0] idx;
        idx        = 3'd0;
        eff_mask_s = ch_mask & CH_LIMIT;
        sel_ok_s   = enable & (|eff_mask_s);
        sel_ch_s   = ptr_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (ptr_q + 3'(i)) & CH_WRAP;
            if (eff_mask_s[idx]) begin
                sel_ch_s = idx;
            end else begin
                sel_ch_s = sel_ch_s;
            end
        end
    end

    // Frame sequencing, SPI pin generation, result capture and stream publishing.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        diff_d   = diff_q;
        adclk_d  = adclk_q;
        cs_d     = cs_q;
        din_d    = din_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        smp_ch_d = smp_ch_q;

        if ((state_q == ST_IDLE) || (state_q == ST_HOLD) || tick_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (valid_q && smp.sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (overrun_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_ok_s) begin
                    state_d = ST_SETUP;
                    ch_d    = sel_ch_s;
                    diff_d  = diff_mode;
                    cs_d    = 1'b0;
                    din_d   = 1'b1;
                    half_d  = {HW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    state_d = ST_SHIFT;
                    half_d  = {HW{1'b0}};
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (tick_s && !half_q[0]) begin
                    adclk_d = 1'b1;
                    half_d  = half_q + 1'b1;
                    if (bit_k_s >= K_DATA) begin
                        shreg_d = {shreg_q[RES_BITS-2:0], DOUT};
                    end else begin
                        shreg_d = shreg_q;
                    end
                end else if (tick_s) begin
                    adclk_d = 1'b0;
                    // DIN moves on the falling edge so the ADC sees it stable at the next rise.
                    case (bit_k_s)
                        K_SGL:   din_d = ~diff_q;
                        K_D2:    din_d = ch_q[2];
                        K_D1:    din_d = ch_q[1];
                        K_D0:    din_d = ch_q[0];
                        default: din_d = 1'b0;
                    endcase
                    if (half_q == SHIFT_LAST) begin
                        cs_d    = 1'b1;
                        state_d = ST_HOLD;
                        half_d  = {HW{1'b0}};
                    end else begin
                        half_d  = half_q + 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (!valid_q || smp.sample_ready) begin
                    data_d   = shreg_q;
                    smp_ch_d = ch_q;
                    valid_d  = 1'b1;
                end else begin
                    ovr_d    = 1'b1;
                end
                ptr_d   = (ch_q + 3'd1) & CH_WRAP;
                half_d  = {HW{1'b0}};
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick_s && (half_q == GAP_LAST)) begin
                    if (sel_ok_s) begin
                        state_d = ST_SETUP;
                        ch_d    = sel_ch_s;
                        diff_d  = diff_mode;
                        cs_d    = 1'b0;
                        din_d   = 1'b1;
                        half_d  = {HW{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tick_s) begin
                    half_d = half_q + 1'b1;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                adclk_d = 1'b0;
                din_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the bus with CS high and AD_CLK low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            half_q   <= {HW{1'b0}};
            ptr_q    <= 3'd0;
            ch_q     <= 3'd0;
            smp_ch_q <= 3'd0;
            diff_q   <= 1'b0;
            adclk_q  <= 1'b0;
            cs_q     <= 1'b1;
            din_q    <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            shreg_q  <= {RES_BITS{1'b0}};
            data_q   <= {RES_BITS{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            smp_ch_q <= smp_ch_d;
            diff_q   <= diff_d;
            adclk_q  <= adclk_d;
            cs_q     <= cs_d;
            din_q    <= din_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
        end
    end

    assign AD_CLK           = adclk_q;
    assign CS               = cs_q;
    assign DIN              = din_q;
    assign overrun          = ovr_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_ch    = smp_ch_q;
    assign smp.sample_valid = valid_q;
endmodule

// File: doc/mcp300x_scan_adc.md
Name: mcp300x_scan_adc

Overview:
Parametrised SPI master for MCP3004/3008 (10-bit) and MCP3204/3208 (12-bit) ADCs. It generates AD_CLK/CS/DIN and round-robin scans the enabled channels. Each channel is converted single-ended or differential. Results go out on a valid/ready stream with a channel tag, and feed the FFT input and 7-seg display paths in place of the fixed 1-channel sequencer.

Parameters:
CLK_DIV, 2700, clk cycles per AD_CLK half-period (AD_CLK period = 2*CLK_DIV clk); legal range >=1
RES_BITS, 10, conversion resolution; legal values 10 or 12
NUM_CH, 8, channels addressable; legal values 4 or 8; mask bits >= NUM_CH are ignored
GAP_HALVES, 2, AD_CLK half-periods with CS high between frames; legal range >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run continuous scan; 0 = stop after current frame
ch_mask  in  8  channel enable bits, bit i = channel i
diff_mode  in  1  1 = differential (SGL/DIFF=0), 0 = single-ended
AD_CLK  out  1  SPI clock to ADC, idle low
CS  out  1  ADC chip select, active low
DIN  out  1  command bits to ADC
DOUT  in  1  conversion bits from ADC
sample_data  out  RES_BITS  converted value, unsigned, MSB first on the wire
sample_ch  out  3  channel that produced sample_data
sample_valid  out  1  sample_data/sample_ch are valid
sample_ready  in  1  consumer accepts when valid&ready at posedge clk
overrun  out  1  sticky: a finished sample was dropped
overrun_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset values (async on rst_n low): AD_CLK=0, CS=1, DIN=0, sample_valid=0, sample_data=0, sample_ch=0, overrun=0, half-period counter=0, scan pointer=0, state=IDLE.
- Tick: a half-period tick pulses every CLK_DIV clk cycles while state != IDLE. The counter restarts at 0 on leaving IDLE.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP or IDLE).
- IDLE: if enable=1 and (ch_mask restricted to NUM_CH) != 0, select the next enabled channel at or after the scan pointer, wrapping from NUM_CH-1 to 0. On the next clk, drive CS=0 and DIN=1 (start bit), then go to SETUP. Otherwise stay in IDLE.
- SETUP: lasts 1 half-period with AD_CLK low, then go to SHIFT.
- SHIFT: N=7+RES_BITS AD_CLK cycles, indexed k=0..N-1.
  - Each cycle is a rising tick followed by a falling tick.
  - DIN sequence on the bits clocked at rising k=0..4: 1, ~diff_mode, ch[2], ch[1], ch[0]. ch[2] is 0 when NUM_CH=4.
  - DIN changes only on falling ticks; it is 0 from falling k=4 onward.
  - diff_mode and the channel number are latched at frame start; mid-frame changes affect the next frame only.
  - k=5 is the sample period and k=6 the null bit; neither is captured.
  - DOUT is captured on rising k=7+j into result bit RES_BITS-1-j, for j=0..RES_BITS-1.
- HOLD: after the last falling tick, CS=1 for one clk, then publish the result and go to GAP.
  - If sample_valid=0, or sample_valid=1 and sample_ready=1 in the same cycle: load sample_data/sample_ch and set sample_valid=1.
  - Otherwise keep the old sample, drop the new one, and set overrun=1.
- Handshake: sample_valid stays high and data stays stable until valid&ready. It clears the cycle after acceptance unless a new publish coincides, in which case the new data is loaded and valid stays 1.
- GAP: CS=1, AD_CLK=0 for GAP_HALVES half-periods.
  - The scan pointer advances to the published channel +1 mod NUM_CH.
  - Then go to SETUP (same selection rule as IDLE) if enable=1 and the mask is non-zero, else IDLE.
- ch_mask is sampled only at channel selection. An all-zero mask, or a mask with only bits >= NUM_CH set, keeps the block in IDLE.
- enable=0 mid-frame: the frame completes and publishes; the block returns to IDLE after GAP.
- overrun_clr and a new overrun in the same cycle: overrun=1 (set wins).
- Reset mid-frame: outputs return to reset values immediately; CS goes high at once.
- Frame length: (1 + 2N) half-periods, plus 1 clk for HOLD, plus GAP_HALVES half-periods.

Test Plan:
1. CLK_DIV=2, RES_BITS=10, ch_mask=8'h01, diff_mode=0, ADC model returns 10'h2A5, ready=1 -> DIN bits 1,1,0,0,0; AD_CLK period 4 clk; 17 rising edges per frame; sample_data=10'h2A5, sample_ch=0.
2. ch_mask=8'b1010_0100, NUM_CH=8 -> sample_ch sequence 2,5,7,2,5.
3. RES_BITS=12, diff_mode=1, ch_mask=8'h08, model returns 12'hABC -> command 1,0,0,1,1; 19 rising edges; sample_data=12'hABC.
4. sample_ready=0 for 3 frames -> first sample held unchanged and valid=1, overrun=1 after frame 2. Then ready=1 with overrun_clr=1 -> first sample accepted, overrun=0.
5. enable dropped at rising k=3 -> frame completes, one sample published, CS stays 1 and state IDLE afterwards. ch_mask=0 with enable=1 -> CS never falls.
6. rst_n low mid-SHIFT -> CS=1, AD_CLK=0, sample_valid=0 asynchronously. After release with enable=1, the first frame starts on the channel-0 scan pointer.
